// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the counter-width helper used by mdu_ctrl.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Wide enough to hold the longer of the two operation latencies.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply / divide datapath producing {hi,lo}.
// Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN with no special case.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_by_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_b_zero;

  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  assign w_b_zero     = (i_b == 32'd0);
  assign w_div_signed = (i_op == MDU_DIV);
  assign w_neg_a      = w_div_signed & i_a[31];
  assign w_neg_b      = w_div_signed & i_b[31];
  assign w_mag_a      = w_neg_a ? (32'd0 - i_a) : i_a;
  // A zero divisor is replaced so the divider never sees it; the result is discarded.
  assign w_mag_b      = w_b_zero ? 32'd1 : (w_neg_b ? (32'd0 - i_b) : i_b);
  assign w_q          = w_mag_a / w_mag_b;
  assign w_r          = w_mag_a % w_mag_b;
  assign w_quot       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q) : w_q;
  assign w_rem        = w_neg_a ? (32'd0 - w_r) : w_r;

  always_comb begin
    o_result      = 64'd0;
    o_div_by_zero = 1'b0;
    case (i_op)
      MDU_MULT:  o_result = w_prod_s;
      MDU_MULTU: o_result = w_prod_u;
      MDU_DIV, MDU_DIVU: begin
        o_result      = {w_rem, w_quot};
        o_div_by_zero = w_b_zero;
      end
      default:   o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner and multi-cycle sequencer for mult/div; stalls dependent D-stage ops.
// A result is held in a pending register and committed on the last busy cycle.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_uses_mdu,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e  r_state;
  mdu_state_e  w_next_state;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_pend;
  logic        r_pend_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_result;
  logic        w_div_by_zero;
  logic        w_idle;
  logic        w_start_arith;
  logic        w_commit;
  logic        w_mthi;
  logic        w_mtlo;

  mdu_arith u_arith (
    .i_op          (mdu_op),
    .i_a           (rs_data),
    .i_b           (rt_data),
    .o_result      (w_result),
    .o_div_by_zero (w_div_by_zero)
  );

  assign w_idle        = (r_state == ST_IDLE);
  assign w_start_arith = start & is_arith(mdu_op) & w_idle;
  assign w_mthi        = start & (mdu_op == MDU_MTHI) & w_idle;
  assign w_mtlo        = start & (mdu_op == MDU_MTLO) & w_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_arith) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CW'(1)) begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pend    <= 64'd0;
      r_pend_dz <= 1'b0;
    end else if (w_start_arith) begin
      r_pend    <= w_result;
      r_pend_dz <= w_div_by_zero;
      r_cnt     <= ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) ? CW'(MULT_CYCLES)
                                                                   : CW'(DIV_CYCLES);
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Divide-by-zero still runs the full sequence but leaves HI/LO untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_pend_dz) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else begin
      if (w_mthi) r_hi <= rs_data;
      if (w_mtlo) r_lo <= rs_data;
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state == ST_RUN);
  assign rd_data  = rd_sel ? r_lo : r_hi;
  assign md_stall = d_uses_mdu & (busy | w_start_arith);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand-written corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_uses_mdu;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t tbl [13];

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mdu_op     (mdu_op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .d_uses_mdu (d_uses_mdu),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .md_stall   (md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return MC;
      3'd3, 3'd4: return DC;
      default:    return 0;
    endcase
  endfunction

  // Reference: plain 64-bit integer arithmetic on the architectural meaning.
  function automatic logic [63:0] model_next(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ch,
                                             input logic [31:0] cl);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; return p; end
      3'd2: begin p = 64'(a) * 64'(b); return p; end
      3'd3: begin
        if (b == 32'd0) return {ch, cl};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {ch, cl};
        return {a % b, a / b};
      end
      3'd5: return {a, cl};
      3'd6: return {ch, a};
      default: return {ch, cl};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    logic [31:0] oh;
    logic [31:0] ol;
    int n;
    oh = m_hi;
    ol = m_lo;
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    #1;
    chk({name, " start_stall"}, {31'd0, md_stall},
        {31'd0, d_uses_mdu & (op inside {[3'd1:3'd4]})});
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      chk({name, " hold_hi"}, hi, oh);
      chk({name, " hold_lo"}, lo, ol);
      if (d_uses_mdu) chk({name, " busy_stall"}, {31'd0, md_stall}, 32'd1);
      n++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, 32'(n), 32'(exp_cycles(op)));
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    rd_sel = 1'b0; #1;
    chk({name, " rd_hi"}, rd_data, eh);
    rd_sel = 1'b1; #1;
    chk({name, " rd_lo"}, rd_data, el);
    chk({name, " idle_stall"}, {31'd0, md_stall}, 32'd0);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] e;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3]  = '{3'd5, 32'h11,       32'd0,        32'h11,       32'hFFFFFFFD};
    tbl[4]  = '{3'd6, 32'h22,       32'd0,        32'h11,       32'h22};
    tbl[5]  = '{3'd4, 32'd7,        32'd0,        32'h11,       32'h22};
    tbl[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    tbl[7]  = '{3'd6, 32'hDEADBEEF, 32'd0,        32'h0,        32'hDEADBEEF};
    tbl[8]  = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    tbl[9]  = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[10] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    tbl[11] = '{3'd0, 32'd5,        32'd5,        32'd1,        32'hFFFFFFFD};
    tbl[12] = '{3'd7, 32'd9,        32'd9,        32'd1,        32'hFFFFFFFD};

    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; rs_data = '0; rt_data = '0;
    d_uses_mdu = 1'b1; rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall", {31'd0, md_stall}, 32'd0);
    reset = 1'b0;
    d_uses_mdu = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, $sformatf("vec%0d", i));

    // Starts of any kind while RUN must be ignored.
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd1; rs_data = 32'd2; rt_data = 32'd3;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      start = (n == 1) || (n == 2);
      mdu_op = (n == 1) ? 3'd5 : 3'd3;
      rs_data = (n == 1) ? 32'hABCD : 32'd9;
      rt_data = 32'd1;
      n++;
      @(negedge clk);
    end
    start = 1'b0; mdu_op = 3'd0;
    chk("ignore busy_cycles", 32'(n), 32'(MC));
    chk("ignore hi", hi, 32'd0);
    chk("ignore lo", lo, 32'd6);
    @(negedge clk);
    chk("ignore no_restart", {31'd0, busy}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd6;

    // Stall window with a dependent instruction in D.
    d_uses_mdu = 1'b1;
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "stall_div");
    run_op(3'd5, 32'h5555, 32'd0, 32'h5555, 32'd14, "stall_mthi");
    run_op(3'd6, 32'h6666, 32'd0, 32'h5555, 32'h6666, "stall_mtlo");

    // Reset in the 4th busy cycle abandons the divide.
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd3; rs_data = 32'd100; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    repeat (3) @(negedge clk);
    chk("midrst busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    chk("midrst stall", {31'd0, md_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst late_hi", hi, 32'd0);
    chk("midrst late_lo", lo, 32'd0);
    chk("midrst late_busy", {31'd0, busy}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      d_uses_mdu = 1'($urandom_range(0, 1));
      e = model_next(op, a, b, m_hi, m_lo);
      run_op(op, a, b, e[63:32], e[31:0], $sformatf("rnd%0d op%0d", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller for the pipelined MIPS core.
- Sits in the EX stage beside the ALU and owns the HI/LO registers.
- Sequences mult/multu/div/divu over a fixed cycle count and handles mthi/mtlo writes.
- Drives `busy` and a stall request to the hazard unit, so MDU-dependent instructions in D are held until the result is committed.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range ≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX-stage MDU instruction valid this cycle.
- mdu_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- rs_data  input  32  operand A (dividend / multiplicand / mt source).
- rt_data  input  32  operand B (divisor / multiplier).
- d_uses_mdu  input  1  D-stage instruction is an MDU op or mfhi/mflo.
- rd_sel  input  1  0 selects HI, 1 selects LO, for mfhi/mflo.
- rd_data  output  32  combinational read of selected HI/LO register.
- hi  output  32  HI register.
- lo  output  32  LO register.
- busy  output  1  operation in progress.
- md_stall  output  1  stall request = d_uses_mdu & (busy | start_arith).

Behaviour:
- Reset: asynchronous, active-high, fixed.
  - hi, lo, busy, internal counter and pending result all clear to 0; state goes to IDLE.
  - Reset mid-operation abandons the operation; HI/LO read 0 afterwards.
- start_arith = start & (mdu_op in 1..4) & state==IDLE.
- States: IDLE, RUN.
- IDLE, when start_arith:
  - Compute the 64-bit result and latch it into a pending register.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Enter RUN; busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - In the cycle counter==1: HI/LO take the pending result at that clock edge, busy drops, state returns to IDLE.
  - Start issued at edge t: busy is high for exactly N cycles, and new HI/LO are visible in the cycle when busy first reads 0.
- MTHI/MTLO in IDLE: hi<=rs_data or lo<=rs_data at the next edge; busy stays 0; single-cycle.
- start with any op while in RUN: ignored. The hazard unit guarantees it cannot occur; the bench checks that it is ignored.
- Arithmetic:
  - MULT: signed 32x32→64; hi=upper, lo=lower.
  - MULTU: unsigned 32x32→64; hi=upper, lo=lower.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): operation still takes DIV_CYCLES and busy asserts; HI/LO unchanged at commit.
- rd_data: purely combinational, rd_sel ? lo : hi. During RUN it shows the old values; the stall prevents consumption.
- md_stall is combinational. It asserts in the start cycle itself, so a dependent instruction directly behind is held.

Decomposition:
- Shared package mdu_pkg holds:
  - mdu_op encodings (MDU_NONE..MDU_MTLO);
  - state encodings;
  - counter width = clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- One sub-module, mdu_arith: purely combinational.
  - Inputs: op, a, b.
  - Outputs: 64-bit {hi,lo} result and div_by_zero flag.
  - mdu_ctrl keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset then MULT rs=0xFFFFFFFE (-2), rt=3:
  - busy high 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
  - hi/lo still 0 during busy.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7, rt=2 → busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=7, rt=0, with prior hi=0x11, lo=0x22 → busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MTLO 0xDEADBEEF in IDLE → lo=0xDEADBEEF next cycle, busy never asserts. MTHI issued during a running MULT is ignored.
- DIV started, d_uses_mdu=1 throughout:
  - md_stall high from the start cycle through the last busy cycle, then low.
  - Assert reset at busy cycle 4: busy=0, hi=lo=0 immediately, with no later commit.
